// File: rtl/tt_eval_pkg.sv
// tt_eval_pkg: shared types and constants for the tt_eval truth-table evaluator.
package tt_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/tt_eval_mem.sv
// tt_eval_mem: 2^IN_W x OUT_W truth table with a registered read port.
// The read register only loads on re, so a stalled result is not disturbed
// by later writes to the same entry. A read and a write to the same address
// in one cycle return the old contents.
module tt_eval_mem #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IN_W-1:0]  waddr,
    input  logic [OUT_W-1:0] wdata,
    input  logic             re,
    input  logic [IN_W-1:0]  raddr,
    output logic [OUT_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << IN_W;

    logic [OUT_W-1:0] mem [DEPTH];

    // Table storage and read register, both cleared synchronously on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/tt_eval.sv
// tt_eval: programmable truth-table evaluator with stream input, built-in
// sweep engine and a registered, back-pressurable result stage.
// Optional feature macro: TT_EVAL_STATS_EN adds the eval_count port.
module tt_eval
    import tt_eval_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IN_W-1:0]   cfg_addr,
    input  logic [OUT_W-1:0]  cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_code,
    input  logic              start,
    input  logic [IN_W-1:0]   sweep_end,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IN_W-1:0]   out_code,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              done
`ifdef TT_EVAL_STATS_EN
    ,
    output logic [STAT_W-1:0] eval_count
`endif
);

    state_t          state;
    state_t          state_nxt;
    logic [IN_W-1:0] cnt;
    logic [IN_W-1:0] end_q;
    logic [IN_W-1:0] rd_addr;
    logic            slot_free;
    logic            start_ok;
    logic            accept_in;
    logic            issue;
    logic            is_last;
    logic            load;
    logic            hs;

    assign slot_free = ~out_valid | out_ready;
    assign start_ok  = start & (state == IDLE);
    // A start pulse wins over a same-cycle input offer.
    assign in_ready  = ~rst & (state == IDLE) & ~start & slot_free;
    assign accept_in = in_valid & in_ready;
    assign issue     = (state == SWEEP) & slot_free;
    assign is_last   = (cnt == end_q);
    assign load      = accept_in | issue;
    assign hs        = out_valid & out_ready;
    assign rd_addr   = issue ? cnt : in_code;

    tt_eval_mem #(
        .IN_W (IN_W),
        .OUT_W(OUT_W)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (cfg_we),
        .waddr(cfg_addr),
        .wdata(cfg_data),
        .re   (load),
        .raddr(rd_addr),
        .rdata(out_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = SWEEP;
            SWEEP:   if (issue && is_last) state_nxt = DRAIN;
            DRAIN:   if (hs && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue counter, sweep limit, output register and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            end_q     <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == DRAIN) & hs & out_last;
            if (start_ok) begin
                end_q <= sweep_end;
                cnt   <= '0;
            end else if (issue && !is_last) begin
                cnt <= cnt + IN_W'(1);
            end
            if (load) begin
                out_valid <= 1'b1;
                out_code  <= rd_addr;
                out_last  <= issue & is_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef TT_EVAL_STATS_EN
    // Saturating count of handshaken results, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            eval_count <= '0;
        end else if (hs && (eval_count != '1)) begin
            eval_count <= eval_count + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tt_eval.sv
// tb_tt_eval: directed self-checking bench for tt_eval.
// Build with TT_EVAL_STATS_EN defined to also check eval_count.
module tb_tt_eval;

    localparam int unsigned IN_W  = 4;
    localparam int unsigned OUT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [IN_W-1:0]  cfg_addr;
    logic [OUT_W-1:0] cfg_data;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic             start;
    logic [IN_W-1:0]  sweep_end;
    logic             out_valid;
    logic             out_ready;
    logic [IN_W-1:0]  out_code;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             done;
`ifdef TT_EVAL_STATS_EN
    logic [15:0]      eval_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tt_eval #(
        .IN_W (IN_W),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .start    (start),
        .sweep_end(sweep_end),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code (out_code),
        .out_data (out_data),
        .out_last (out_last),
        .done     (done)
`ifdef TT_EVAL_STATS_EN
        ,
        .eval_count(eval_count)
`endif
    );

    // Reference function: o0 = i0 & (~i1 | ~i3), o1 = ~i0; data = {o1, o0}.
    function automatic logic [1:0] ref_f(input logic [3:0] c);
        return {~c[0], c[0] & (~c[1] | ~c[3])};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_code !== 4'd0) begin bad++; $display("FAIL rst_out_code got=%0d want=0", out_code); end
        total++; if (out_data !== 2'd0) begin bad++; $display("FAIL rst_out_data got=%b want=00", out_data); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", out_last); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
`ifdef TT_EVAL_STATS_EN
        total++; if (eval_count !== 16'd0) begin bad++; $display("FAIL rst_eval_count got=%0d want=0", eval_count); end
`endif
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic program_table();
        for (int i = 0; i < 16; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = 4'(i);
            cfg_data = ref_f(4'(i));
            step();
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_stream();
        logic [3:0] codes [5];
        logic [1:0] exp_d [5];
        codes = '{4'd5, 4'd3, 4'd2, 4'd11, 4'd9};
        exp_d = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code  = codes[i];
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b want=1", i, in_ready); end
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, out_valid); end
            total++; if (out_code !== codes[i]) begin bad++; $display("FAIL stream_code[%0d] got=%0d want=%0d", i, out_code, codes[i]); end
            total++; if (out_data !== exp_d[i]) begin bad++; $display("FAIL stream_data[%0d] got=%b want=%b", i, out_data, exp_d[i]); end
            total++; if (out_last !== 1'b0) begin bad++; $display("FAIL stream_last[%0d] got=%b want=0", i, out_last); end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        in_code  = 4'd3;
        step();
        out_ready = 1'b0;
        in_code   = 4'd11;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", k, out_valid); end
            total++; if (out_code !== 4'd3) begin bad++; $display("FAIL bp_code[%0d] got=%0d want=3", k, out_code); end
            total++; if (out_data !== 2'b01) begin bad++; $display("FAIL bp_data[%0d] got=%b want=01", k, out_data); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", k, in_ready); end
            // Rewrite the held entry during the stall, then restore it.
            cfg_we   = (k < 2);
            cfg_addr = 4'd3;
            cfg_data = (k == 0) ? 2'b10 : 2'b01;
            step();
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        #1;
        total++; if (out_code !== 4'd3) begin bad++; $display("FAIL bp_release_code got=%0d want=3", out_code); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b want=1", out_valid); end
        total++; if (out_code !== 4'd11) begin bad++; $display("FAIL bp_next_code got=%0d want=11", out_code); end
        total++; if (out_data !== 2'b00) begin bad++; $display("FAIL bp_next_data got=%b want=00", out_data); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", out_valid); end
    endtask

    task automatic test_rw_collision();
        in_valid = 1'b1;
        in_code  = 4'd5;
        cfg_we   = 1'b1;
        cfg_addr = 4'd5;
        cfg_data = 2'b11;
        step();
        cfg_we = 1'b0;
        total++; if (out_data !== 2'b01) begin bad++; $display("FAIL rw_old got=%b want=01", out_data); end
        step();
        total++; if (out_data !== 2'b11) begin bad++; $display("FAIL rw_new got=%b want=11", out_data); end
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_data = 2'b01;
        step();
        cfg_we = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_sweep(input int unsigned last);
        sweep_end = 4'(last);
        start     = 1'b1;
        step();
        start = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sweep%0d_lat got=%b want=0", last, out_valid); end
        for (int unsigned i = 0; i <= last; i++) begin
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sweep%0d_valid[%0d] got=%b want=1", last, i, out_valid); end
            total++; if (out_code !== 4'(i)) begin bad++; $display("FAIL sweep%0d_code[%0d] got=%0d want=%0d", last, i, out_code, i); end
            total++; if (out_data !== ref_f(4'(i))) begin bad++; $display("FAIL sweep%0d_data[%0d] got=%b want=%b", last, i, out_data, ref_f(4'(i))); end
            total++; if (out_last !== (i == last)) begin bad++; $display("FAIL sweep%0d_last[%0d] got=%b want=%b", last, i, out_last, (i == last)); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL sweep%0d_early_done[%0d] got=%b want=0", last, i, done); end
        end
        step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL sweep%0d_done got=%b want=1", last, done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sweep%0d_end_valid got=%b want=0", last, out_valid); end
`ifdef TT_EVAL_STATS_EN
        total++; if (eval_count !== 16'(last + 1)) begin bad++; $display("FAIL sweep%0d_count got=%0d want=%0d", last, eval_count, last + 1); end
`endif
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL sweep%0d_done_pulse got=%b want=0", last, done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sweep%0d_no_wrap got=%b want=0", last, out_valid); end
    endtask

    task automatic test_start_ignored();
        int dones;
        dones     = 0;
        sweep_end = 4'd3;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_code   = 4'd7;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ign_start_in_ready got=%b want=0", in_ready); end
        step();
        sweep_end = 4'd15;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ign_sweep_in_ready got=%b want=0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (done === 1'b1) dones++;
            total++; if (out_code !== 4'(i)) begin bad++; $display("FAIL ign_code[%0d] got=%0d want=%0d", i, out_code, i); end
            total++; if (out_last !== (i == 3)) begin bad++; $display("FAIL ign_last[%0d] got=%b want=%b", i, out_last, (i == 3)); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ign_in_ready[%0d] got=%b want=0", i, in_ready); end
        end
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        if (done === 1'b1) dones++;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ign_drain_valid got=%b want=0", out_valid); end
        for (int i = 0; i < 2; i++) begin
            step();
            if (done === 1'b1) dones++;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ign_restart[%0d] got=%b want=0", i, out_valid); end
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", dones); end
    endtask

    task automatic test_reset_mid_sweep();
        sweep_end = 4'd15;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (out_code !== 4'(i)) begin bad++; $display("FAIL mrst_code[%0d] got=%0d want=%0d", i, out_code, i); end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b want=0", out_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mrst_done got=%b want=0", done); end
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_idle got=%b want=1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ((done | out_valid) !== 1'b0) begin bad++; $display("FAIL mrst_quiet[%0d] got=%b%b want=00", i, done, out_valid); end
        end
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_code  = 4'(i);
            step();
            total++; if (out_data !== 2'b00) begin bad++; $display("FAIL mrst_cleared[%0d] got=%b want=00", i, out_data); end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_code   = '0;
        start     = 1'b0;
        sweep_end = '0;
        out_ready = 1'b1;
        test_reset();
        program_table();
        test_stream();
        test_backpressure();
        test_rw_collision();
        test_sweep(9);
        test_sweep(0);
        test_sweep(15);
        test_start_ignored();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/tt_eval.md
# tt_eval

Programmable truth-table evaluator generalising the fixed 4-input/2-output minimised function to IN_W inputs and OUT_W outputs. It has a runtime-writable table, a valid/ready stream interface, and a built-in sweep engine that emits every code from 0 to a programmed limit. It sits between a code source (switches, counter, or upstream stream) and any consumer of the function outputs, and serves as the lab's reusable combinational-function block with registered, back-pressurable results.

## Interface
- IN_W, 4, input code width; table depth 2^IN_W
- OUT_W, 2, output function width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  IN_W  table entry written
- cfg_data  in  OUT_W  value written
- in_valid  in  1  input code offered
- in_ready  out  1  block accepts input code
- in_code  in  IN_W  input code
- start  in  1  one-cycle pulse, begin sweep
- sweep_end  in  IN_W  last sweep code, sampled on accepted start
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_code  out  IN_W  code that produced out_data
- out_data  out  OUT_W  table[out_code]
- out_last  out  1  result is final sweep code
- done  out  1  one-cycle pulse, sweep complete
- eval_count  out  16  handshaken results (only with TT_EVAL_STATS_EN)

## Operation
- Table: 2^IN_W x OUT_W, cleared to 0 on rst; write on cfg_we in any state.
- Same-cycle read and write of one address: read returns old value; the write is visible from the next cycle.
- in_ready = (state==IDLE) & (~out_valid | out_ready). Accepted code loads out_code/out_data next cycle with out_valid=1 and out_last=0.
- FSM states IDLE, SWEEP, DRAIN:
  - IDLE: start latches sweep_end, sets issue counter to 0, and moves to SWEEP. A start pulse in the same cycle as in_valid is taken; the input is refused (in_ready=0 that cycle).
  - SWEEP: issue counter value enters the pipeline whenever ~out_valid | out_ready, then increments. When sweep_end is issued, out_last is set for that result and the FSM moves to DRAIN.
  - DRAIN: on the out_valid & out_ready & out_last handshake, go to IDLE and assert done in the following cycle.
- start outside IDLE is ignored.
- sweep_end = 2^IN_W−1 issues every code. The counter stops at sweep_end and never wraps.
- sweep_end = 0 issues a single code 0 with out_last=1.
- Held outputs: while out_valid & ~out_ready, out_code, out_data and out_last stay stable, even if the table entry is rewritten.

## Timing
- Reset values: in_ready 0 during rst, then 1; out_valid 0; out_code 0; out_data 0; out_last 0; done 0; eval_count 0; state IDLE.
- Latency is 1 cycle from input or issue to out_valid.
- Throughput is 1 result per cycle with out_ready held high.
- Sweep of N codes with no backpressure: start at cycle t; first out_valid at t+2; out_last at t+N+1; done at t+N+2.
- rst mid-sweep: next cycle is IDLE with out_valid 0 and the table cleared. No done is produced.

## Configuration
- TT_EVAL_STATS_EN defined:
  - eval_count port is present. It increments on each out_valid & out_ready and saturates at 16'hFFFF.
  - It clears on rst and on an accepted start.
- Macro undefined: no eval_count port and no counter logic. All other behaviour is identical.

## Structure
- Package tt_eval_pkg:
  - typedef enum for the FSM states IDLE/SWEEP/DRAIN
  - constant STAT_W = 16
- Sub-module tt_eval_mem holds the table: synchronous registered read, read-before-write, and synchronous clear on rst.
- The top level holds the FSM, issue counter, output register/handshake and optional stats.

## Test plan
- Default parameters; program table with o0=i0&(~i1|~i3), o1=~i0; stream codes 5,3,2,11,9 with out_ready=1 -> out_data 01,01,10,00,01, each one cycle after acceptance.
- Same table; start with sweep_end=9 -> codes 0..9 on consecutive cycles; out_last only with code 9; done one cycle later; eval_count=10 with the macro.
- Mid-stream, hold out_ready low for 3 cycles -> out_code/out_data unchanged, in_ready=0, no result lost or duplicated.
- cfg_we to addr 5 with 2'b11 in the same cycle code 5 is accepted -> result 01; next code 5 -> 11.
- Assert rst during a sweep with sweep_end=15 at the 4th result -> out_valid 0 next cycle, no done; table reads 00 for every code afterwards.
- Assert start during SWEEP and during DRAIN, plus in_valid=1 throughout the sweep -> both ignored; only sweep codes emitted; exactly one done.
